mips_stage_sequencer: RTL and testbench

//  Multicycle stage/PC sequencer for the MIPS core, parametrised in PC width, program depth and stage count.

---
 rtl/mips_stage_sequencer_pkg.sv | 13 +
 rtl/mips_stage_sequencer_if.sv | 21 ++
 rtl/mips_pc_next.sv | 19 +
 rtl/mips_stage_sequencer.sv | 64 ++++++
 tb/tb_mips_stage_sequencer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mips_stage_sequencer_pkg.sv
// mips_stage_sequencer_pkg: stage and sequencer FSM encodings shared by the MIPS core.
package mips_stage_sequencer_pkg;
  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;
  localparam int STG_ALU    = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_RUN    = 2'd1,
    SEQ_HALTED = 2'd2
  } seq_state_t;
endpackage

// File: rtl/mips_stage_sequencer_if.sv
// mips_stage_sequencer_if: control inputs and stage/pc status outputs of the sequencer.
interface mips_stage_sequencer_if #(
  parameter int PC_W       = 4,
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = 3,
  parameter int CNT_W      = 16
);
  logic                  stall;
  logic                  branch;
  logic [31:0]           branch_value;
  logic                  end_program;
  logic [PC_W-1:0]       pc;
  logic [STAGE_W-1:0]    stage;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  halted;
  logic [CNT_W-1:0]      retired;
  modport master (output stall, branch, branch_value, end_program,
                  input  pc, stage, stage_en, halted, retired);
  modport slave  (input  stall, branch, branch_value, end_program,
                  output pc, stage, stage_en, halted, retired);
endinterface

// File: rtl/mips_pc_next.sv
// mips_pc_next: next instruction address, sequential or branch-relative, wrapped modulo IMEM_DEPTH.
module mips_pc_next #(
  parameter int PC_W       = 4,
  parameter int IMEM_DEPTH = 9
) (
  input  logic [PC_W-1:0] pc,
  input  logic            branch,
  input  logic [31:0]     branch_value,
  output logic [PC_W-1:0] pc_next
);
  localparam logic signed [32:0] DEPTH = 33'(IMEM_DEPTH);
  logic signed [32:0] sum, rem, res;
  assign sum = $signed({{(33-PC_W){1'b0}}, pc}) + 33'sd1
             + (branch ? $signed({branch_value[31], branch_value}) : 33'sd0);
  // signed % keeps the dividend's sign, so fold negatives back into range
  assign rem = sum % DEPTH;
  assign res = (rem < 0) ? rem + DEPTH : rem;
  assign pc_next = PC_W'(res);
endmodule

// File: rtl/mips_stage_sequencer.sv
// mips_stage_sequencer: multicycle stage/PC sequencer with stall, halt FSM and retired counter.
module mips_stage_sequencer
  import mips_stage_sequencer_pkg::*;
#(
  parameter int PC_W       = 4,
  parameter int IMEM_DEPTH = 9,
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = 3,
  parameter int START_PC   = 8,
  parameter int CNT_W      = 16
) (
  input logic                   clock,
  input logic                   reset,
  mips_stage_sequencer_if.slave bus
);
  seq_state_t         state_q, state_n;
  logic [STAGE_W-1:0] stage_q, stage_n;
  logic [PC_W-1:0]    pc_q, pc_n, pc_adv;
  logic [CNT_W-1:0]   ret_q, ret_n;
  logic               last;

  mips_pc_next #(.PC_W(PC_W), .IMEM_DEPTH(IMEM_DEPTH)) u_pc_next (
    .pc(pc_q), .branch(bus.branch), .branch_value(bus.branch_value), .pc_next(pc_adv)
  );

  assign last = stage_q == STAGE_W'(NUM_STAGES-1);

  always_ff @(negedge clock or negedge reset)
    if (!reset) begin
      state_q <= SEQ_IDLE;
      stage_q <= STAGE_W'(NUM_STAGES-1);
      pc_q    <= PC_W'(START_PC);
      ret_q   <= '0;
    end else begin
      state_q <= state_n;
      stage_q <= stage_n;
      pc_q    <= pc_n;
      ret_q   <= ret_n;
    end

  always_comb begin
    state_n = state_q;
    stage_n = stage_q;
    pc_n    = pc_q;
    ret_n   = ret_q;
    if (state_q == SEQ_IDLE) begin
      state_n = SEQ_RUN;
      stage_n = STAGE_W'(STG_FETCH);
    end else if (state_q == SEQ_RUN) begin
      if (bus.end_program) state_n = SEQ_HALTED;
      else if (!bus.stall) begin
        stage_n = last ? STAGE_W'(STG_FETCH) : stage_q + STAGE_W'(1);
        pc_n    = last ? pc_adv : pc_q;
        ret_n   = (last && !(&ret_q)) ? ret_q + CNT_W'(1) : ret_q;
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.stage    = stage_q;
  assign bus.stage_en = (state_q == SEQ_RUN) ? NUM_STAGES'(1) << stage_q : '0;
  assign bus.halted   = state_q == SEQ_HALTED;
  assign bus.retired  = ret_q;
endmodule

// File: tb/tb_mips_stage_sequencer.sv
// tb_mips_stage_sequencer: directed scenarios checked against a behavioural scoreboard model.
module tb_mips_stage_sequencer;
  logic clock = 1'b1;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  typedef struct {
    int pc;
    int stage;
    int en;
    int halted;
    int ret;
  } exp_t;
  exp_t q[$];

  int m_state, m_pc, m_stage, m_ret;

  mips_stage_sequencer_if #(.CNT_W(16)) bus ();
  mips_stage_sequencer_if #(.CNT_W(2))  bus2 ();

  mips_stage_sequencer dut (.clock(clock), .reset(reset), .bus(bus));
  mips_stage_sequencer #(.CNT_W(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.pc = m_pc;
    e.stage = m_stage;
    e.en = (m_state == 1) ? (1 << m_stage) : 0;
    e.halted = (m_state == 2) ? 1 : 0;
    e.ret = m_ret;
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_empty", 64'd1, 64'd0);
      return;
    end
    e = q.pop_front();
    chk("pc", 64'(bus.pc), 64'(e.pc));
    chk("stage", 64'(bus.stage), 64'(e.stage));
    chk("stage_en", 64'(bus.stage_en), 64'(e.en));
    chk("halted", 64'(bus.halted), 64'(e.halted));
    chk("retired", 64'(bus.retired), 64'(e.ret));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_state = 0; m_pc = 8; m_stage = 4; m_ret = 0;
    q.push_back(model_exp());
    compare_head();
    chk("sat_reset", 64'(bus2.retired), 64'd0);
    #1 reset = 1'b1;
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] bv, input logic e);
    longint t;
    bus.stall = s; bus.branch = b; bus.branch_value = bv; bus.end_program = e;
    if (m_state == 0) begin
      m_state = 1; m_stage = 0;
    end else if (m_state == 1) begin
      if (e) m_state = 2;
      else if (!s) begin
        if (m_stage == 4) begin
          t = longint'(m_pc) + 1 + (b ? longint'($signed(bv)) : 64'sd0);
          m_pc = int'(((t % 9) + 9) % 9);
          m_stage = 0;
          if (m_ret < 65535) m_ret++;
        end else m_stage++;
      end
    end
    q.push_back(model_exp());
    @(negedge clock);
    @(posedge clock);
    compare_head();
  endtask

  task automatic run_to(input int p, input int st);
    int n = 0;
    while ((m_pc != p || m_stage != st) && n < 200) begin
      step(0, 0, 0, 0);
      n++;
    end
    chk("reach_target", 64'(n < 200), 64'd1);
  endtask

  initial begin
    int ret_at_halt;
    bus.stall = 0; bus.branch = 0; bus.branch_value = 0; bus.end_program = 0;
    bus2.stall = 0; bus2.branch = 0; bus2.branch_value = 0; bus2.end_program = 0;
    #1 do_reset();
    step(0, 0, 0, 0);
    chk("first_pc", 64'(bus.pc), 64'd8);
    chk("first_en", 64'(bus.stage_en), 64'b00001);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("wrap_pc", 64'(bus.pc), 64'd1);
    chk("wrap_ret", 64'(bus.retired), 64'd2);
    run_to(2, 4);
    step(0, 1, -32'sd3, 0);
    chk("branch_neg3", 64'(bus.pc), 64'd0);
    step(0, 1, 32'd5, 0);
    run_to(1, 4);
    step(0, 1, -32'sd5, 0);
    chk("branch_neg5", 64'(bus.pc), 64'd6);
    run_to(6, 4);
    step(0, 1, 32'h7fff_ffff, 0);
    run_to(m_pc, 4);
    step(0, 1, 32'h8000_0000, 0);
    run_to(m_pc, 2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    chk("stall_stage", 64'(bus.stage), 64'd2);
    step(0, 0, 0, 0);
    run_to(5, 1);
    ret_at_halt = m_ret;
    step(1, 0, 0, 1);
    chk("halt_pc", 64'(bus.pc), 64'd5);
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
    chk("halt_ret", 64'(bus.retired), 64'(ret_at_halt));
    chk("halt_flag", 64'(bus.halted), 64'd1);
    bus.end_program = 0; bus.stall = 0; bus.branch = 0;
    do_reset();
    step(0, 0, 0, 0);
    run_to(m_pc, 3);
    #2 reset = 1'b0;
    #1;
    m_state = 0; m_pc = 8; m_stage = 4; m_ret = 0;
    q.push_back(model_exp());
    compare_head();
    #1 reset = 1'b1;
    step(0, 0, 0, 0);
    chk("restart_pc", 64'(bus.pc), 64'd8);
    for (int i = 0; i < 25; i++) step(0, 0, 0, 0);
    chk("five_retired", 64'(bus.retired), 64'd5);
    chk("sat_retired", 64'(bus2.retired), 64'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
